rst_sequencer: RTL and testbench
================================

# rst_sequencer

Parametrised reset sequencer replacing the single fixed-length reset pulse currently driven into `top`. Takes the board-level asynchronous active-low reset plus a software reset request, stretches it to a guaranteed minimum, then releases `NUM_CH` downstream reset domains one at a time. Each domain must acknowledge readiness, or time out, before the next is released. Sits directly under `top`, between the reset pin and every functional sub-block.

## Interface
- `NUM_CH`, 4: number of sequenced reset channels, 1..16.
- `HOLD_CYCLES`, 16: minimum cycles all channels stay asserted after the reset cause ends, ≥1.
- `STAGGER_CYCLES`, 8: gap from channel i readiness to channel i+1 release, ≥1.
- `TIMEOUT_CYCLES`, 1024: maximum wait for `ch_ready[i]` after channel i is released, ≥1.

- `clk`  in  1  single system clock; all logic in this domain.
- `nreset`  in  1  reset, asynchronous, active-low.
- `soft_rst_req`  in  1  synchronous software reset request, level-sensitive.
- `ch_ready`  in  NUM_CH  per-channel "out of reset and ready" indication, synchronous to `clk`.
- `ch_rst_n`  out  NUM_CH  per-channel active-low reset, registered.
- `busy`  out  1  sequence in progress.
- `ready`  out  1  all channels released and sequence complete.
- `done`  out  1  single-cycle pulse on sequence completion.
- `err`  out  NUM_CH  sticky per-channel timeout flags.

## Operation
- States:
  - HOLD: all channels asserted; counter counts hold cycles.
  - WAIT(i): channel i released; counter counts toward timeout.
  - STAGGER(i): gap before channel i+1 is released.
  - RUN: sequence complete.
- `nreset` low, asynchronously:
  - all `ch_rst_n`=0, `err`=0, `busy`=1, `ready`=0, `done`=0.
  - state=HOLD, counter=0, channel index=0.
- `nreset` deassertion passes through a 2-flop synchroniser. HOLD starts counting only once the synchronised reset is high.
- HOLD: counter increments each cycle. When counter = HOLD_CYCLES−1, on the next edge: `ch_rst_n[0]`←1, counter←0, state←WAIT(0).
- WAIT(i): `ch_ready[i]` sampled each edge.
  - If 1: if i=NUM_CH−1, go to RUN; otherwise go to STAGGER(i) with counter←0.
  - If counter reaches TIMEOUT_CYCLES−1 with `ch_ready[i]`=0: `err[i]`←1 and proceed exactly as if ready had been seen. The channel stays released (degraded mode, no retry).
- STAGGER(i): when counter = STAGGER_CYCLES−1, on the next edge: `ch_rst_n[i+1]`←1, counter←0, state←WAIT(i+1).
- Entry to RUN: `busy`←0, `ready`←1, `done`=1 for exactly that one cycle.
- `ch_ready` of unreleased channels is ignored. `ch_ready` deasserting in RUN is ignored.
- `soft_rst_req`=1 sampled in any state:
  - on that edge: all `ch_rst_n`←0, `err`←0, `ready`←0, `busy`←1, counter←0, state←HOLD.
  - While it is held high, the counter stays at 0. HOLD counting begins on the first edge with the request low.
- `nreset` assertion overrides everything, at any time, including mid-sequence.
- Released channels never re-assert except on `nreset` low or `soft_rst_req`.

## Timing
- `ch_rst_n[0]` rises on the (2+HOLD_CYCLES)th rising edge after `nreset` goes high. With defaults this is the 18th edge.
- After a soft reset, `ch_rst_n[0]` rises on the HOLD_CYCLES-th edge after the request is first sampled low (no synchroniser delay).
- Readiness or timeout of channel i at edge T: `ch_rst_n[i+1]` rises at edge T+STAGGER_CYCLES.
- Timeout of channel i is flagged at the TIMEOUT_CYCLES-th edge after `ch_rst_n[i]` rises.
- `ready`/`done` rise on the same edge that last-channel readiness or timeout is sampled.
- All outputs are registered. No combinational input→output path.

## Structure
- Package `rst_seq_pkg` holds:
  - the state enum (HOLD, WAIT, STAGGER, RUN);
  - a `clog2`-based width helper;
  - counter width, defined as the bit width of max(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES), and channel-index width.
- One sub-module, `rst_sync`: 2-flop synchroniser with asynchronous assert and synchronous deassert, instantiated on `nreset`. It is reusable by other domains.
- The main FSM, shared counter and channel index live in `rst_sequencer`.

## Test plan
1. Defaults, `ch_ready` tied high 1 cycle after each release:
   - channel 0 releases at edge 18, channel 1 at 27, channel 2 at 36, channel 3 at 45;
   - `done` pulses once at edge 46, `ready`=1, `err`=0.
2. `ch_ready[1]` never asserts, TIMEOUT_CYCLES=32:
   - `err[1]` is set 32 edges after channel 1 releases, then channel 2 releases 8 edges later;
   - final `err`=4'b0010 with `ready`=1.
3. `nreset` pulsed low while in WAIT(2): all `ch_rst_n` go 0 before the next edge and `err` clears. The sequence then restarts, with channel 0 releasing at edge 18.
4. `soft_rst_req` held high for 5 cycles in RUN:
   - all channels reassert on the first sampled edge;
   - channel 0 rises 16 edges after the request drops.
5. NUM_CH=1, HOLD_CYCLES=1, STAGGER_CYCLES=1: channel 0 releases at edge 3, and `done` fires on the edge that `ch_ready[0]` is sampled.
6. `ch_ready[3]` driven high from reset: it is ignored until channel 3 is released, and no early RUN occurs.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer and its sub-blocks.
package rst_seq_pkg;

    // Sequencer phases: stretch, wait for a released channel, gap, done.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_STAGGER = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // Number of bits needed to represent 'value', never less than one.
    function automatic int bits_for(input int value);
        int w;
        w = $clog2(value + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One shared counter serves hold, stagger and timeout, so size it for the largest.
    function automatic int cnt_width(input int hold, input int stagger, input int timeout);
        return bits_for(max3(hold, stagger, timeout));
    endfunction

    function automatic int idx_width(input int num_ch);
        return bits_for(num_ch - 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the clock
// two edges after the raw reset goes high.
module rst_sync (
    input  logic i_clk,
    input  logic i_arst_n,
    output logic o_rst_n
);

    logic r_meta;
    logic r_sync;

    // Shift a constant 1 through two flops; the async clear gives immediate assertion.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= 1'b1;
            r_sync <= r_meta;
        end
    end

    assign o_rst_n = r_sync;

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: stretches the board / software reset, then releases the
// downstream reset domains one at a time, waiting for each to report ready
// (or time out) and leaving a fixed gap before releasing the next.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              soft_rst_req,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              busy,
    output logic              ready,
    output logic              done,
    output logic [NUM_CH-1:0] err
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES);
    localparam int IDX_W = idx_width(NUM_CH);

    localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] CH_ONE       = NUM_CH'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [NUM_CH-1:0] r_ch_rst_n;
    logic [NUM_CH-1:0] w_ch_rst_n_nxt;
    logic [NUM_CH-1:0] r_err;
    logic [NUM_CH-1:0] w_err_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_ready;
    logic              w_ready_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic              w_rst_sync;
    logic [NUM_CH-1:0] w_cur_mask;
    logic              w_cur_ready;

    rst_sync u_nreset_sync (
        .i_clk    (clk),
        .i_arst_n (nreset),
        .o_rst_n  (w_rst_sync)
    );

    // One-hot select of the channel currently being waited on; masking instead
    // of indexing keeps unreleased channels' ready inputs out of the decision.
    assign w_cur_mask  = CH_ONE << r_idx;
    assign w_cur_ready = |(ch_ready & w_cur_mask);

    // State, counter, index and every output are registered here.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= ST_HOLD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_ch_rst_n <= '0;
            r_err      <= '0;
            r_busy     <= 1'b1;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_ch_rst_n <= w_ch_rst_n_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_ready    <= w_ready_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state logic; a software request pre-empts every state and parks in HOLD.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_ch_rst_n_nxt = r_ch_rst_n;
        w_err_nxt      = r_err;
        w_busy_nxt     = r_busy;
        w_ready_nxt    = r_ready;
        w_done_nxt     = 1'b0;

        if (soft_rst_req) begin
            w_state_nxt    = ST_HOLD;
            w_cnt_nxt      = '0;
            w_idx_nxt      = '0;
            w_ch_rst_n_nxt = '0;
            w_err_nxt      = '0;
            w_busy_nxt     = 1'b1;
            w_ready_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    // Stretch only starts once the synchronised board reset has lifted.
                    if (w_rst_sync) begin
                        if (r_cnt == HOLD_LAST) begin
                            w_ch_rst_n_nxt = r_ch_rst_n | CH_ONE;
                            w_cnt_nxt      = '0;
                            w_idx_nxt      = '0;
                            w_state_nxt    = ST_WAIT;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // A timeout is handled exactly like readiness, plus a sticky flag;
                    // the channel is left released.
                    if (w_cur_ready || (r_cnt == TIMEOUT_LAST)) begin
                        if (!w_cur_ready) begin
                            w_err_nxt = r_err | w_cur_mask;
                        end
                        w_cnt_nxt = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = ST_RUN;
                            w_busy_nxt  = 1'b0;
                            w_ready_nxt = 1'b1;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_STAGGER;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_STAGGER: begin
                    if (r_cnt == STAGGER_LAST) begin
                        w_ch_rst_n_nxt = r_ch_rst_n | (w_cur_mask << 1);
                        w_idx_nxt      = r_idx + 1'b1;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = ST_WAIT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    // RUN: hold everything; late changes on ch_ready are ignored.
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign ch_rst_n = r_ch_rst_n;
    assign err      = r_err;
    assign busy     = r_busy;
    assign ready    = r_ready;
    assign done     = r_done;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer. Two instances: a 4-channel one and a
// minimal 1-channel one. Expected release/done edges come from an event-level
// model: release(0) = start + hold, ack(i) = release(i) + min(ready delay, timeout),
// release(i+1) = ack(i) + stagger, done at ack(last).
module tb_rst_sequencer;

    typedef struct {
        int          kind;    // 0 = channel release, 1 = done pulse
        int          ch;
        int          edge_n;
        logic [15:0] err;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       rstn0 = 1'b0, rstn1 = 1'b0;
    logic       soft0 = 1'b0, soft1 = 1'b0;
    logic [3:0] rdy_v0 = '0;
    logic [0:0] rdy_v1 = '0;
    logic [3:0] ch0, err0;
    logic [0:0] ch1, err1;
    logic       busy0, ready0, done0, busy1, ready1, done1;

    int          rdy_at [2][16];   // edge after which ready is driven high; -1 never
    int          dly [16];         // >0 sample delay after release, 0 high from start, -1 never
    int          exp_r [16];
    ev_t         q0[$];
    ev_t         q1[$];
    logic [15:0] prev_ch [2] = '{16'h0, 16'h0};

    rst_sequencer #(
        .NUM_CH(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(8), .TIMEOUT_CYCLES(32)
    ) u_dut0 (
        .clk(clk), .nreset(rstn0), .soft_rst_req(soft0), .ch_ready(rdy_v0),
        .ch_rst_n(ch0), .busy(busy0), .ready(ready0), .done(done0), .err(err0)
    );

    rst_sequencer #(
        .NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .TIMEOUT_CYCLES(4)
    ) u_dut1 (
        .clk(clk), .nreset(rstn1), .soft_rst_req(soft1), .ch_ready(rdy_v1),
        .ch_rst_n(ch1), .busy(busy1), .ready(ready1), .done(done1), .err(err1)
    );

    function automatic int cfg_n(input int d); return (d == 0) ? 4 : 1; endfunction
    function automatic int cfg_h(input int d); return (d == 0) ? 16 : 1; endfunction
    function automatic int cfg_s(input int d); return (d == 0) ? 8 : 1; endfunction
    function automatic int cfg_t(input int d); return (d == 0) ? 32 : 4; endfunction

    function automatic logic [15:0] get_ch(input int d);
        return (d == 0) ? {12'h0, ch0} : {15'h0, ch1};
    endfunction
    function automatic logic [15:0] get_err(input int d);
        return (d == 0) ? {12'h0, err0} : {15'h0, err1};
    endfunction
    function automatic logic [2:0] get_flags(input int d);
        return (d == 0) ? {busy0, ready0, done0} : {busy1, ready1, done1};
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, d, cyc, act, exp_v);
        end
    endtask

    task automatic push_ev(input int d, input ev_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask
    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction
    task automatic pop_ev(input int d, output ev_t e);
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
    endtask
    task automatic flush(input int d);
        if (d == 0) q0.delete(); else q1.delete();
    endtask
    task automatic clear_rdy(input int d);
        for (int i = 0; i < 16; i++) rdy_at[d][i] = -1;
    endtask
    task automatic set_rstn(input int d, input logic v);
        if (d == 0) rstn0 = v; else rstn1 = v;
    endtask
    task automatic set_soft(input int d, input logic v);
        if (d == 0) soft0 = v; else soft1 = v;
    endtask
    task automatic set_dly(input int a, input int b, input int c, input int e);
        for (int i = 0; i < 16; i++) dly[i] = -1;
        dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = e;
    endtask

    // Monitor: compare every release edge and done pulse against the queue.
    task automatic mon(input int d);
        logic [15:0] ch;
        logic [15:0] rise;
        logic [2:0]  fl;
        ev_t         e;
        ch   = get_ch(d);
        fl   = get_flags(d);
        rise = ch & ~prev_ch[d];
        for (int i = 0; i < 16; i++) begin
            if (rise[i]) begin
                if (q_size(d) == 0) begin
                    chk("unexpected_release", d, rise[i], 0);
                end else begin
                    pop_ev(d, e);
                    chk("release_ch", d, i, e.ch);
                    chk("release_edge", d, cyc, e.edge_n);
                end
            end
        end
        if (fl[0]) begin
            if (q_size(d) == 0) begin
                chk("unexpected_done", d, fl[0], 0);
            end else begin
                pop_ev(d, e);
                chk("done_kind", d, 1, e.kind);
                chk("done_edge", d, cyc, e.edge_n);
                chk("done_err", d, get_err(d), e.err);
                chk("done_ready", d, fl[1], 1);
                chk("done_busy", d, fl[2], 0);
            end
        end
        prev_ch[d] = ch;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(0);
            mon(1);
        end
    end

    // Ready driver: levels follow the planned schedule, settled before the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int i = 0; i < 4; i++) rdy_v0[i] = (rdy_at[0][i] >= 0) && (cyc >= rdy_at[0][i]);
            rdy_v1[0] = (rdy_at[1][0] >= 0) && (cyc >= rdy_at[1][0]);
        end
    end

    // Reference model: schedule every release and the done pulse from the delays.
    task automatic plan(input int d, input int r0, output int a_last, output logic [15:0] eerr);
        int  r, a, eff;
        ev_t e;
        eerr = '0;
        r    = r0;
        a    = r0;
        clear_rdy(d);
        for (int i = 0; i < cfg_n(d); i++) begin
            exp_r[i] = r;
            e.kind = 0; e.ch = i; e.edge_n = r; e.err = '0;
            push_ev(d, e);
            if (dly[i] == 0)      rdy_at[d][i] = 0;
            else if (dly[i] > 0)  rdy_at[d][i] = r + dly[i] - 1;
            eff = (dly[i] == 0) ? 1 : dly[i];
            if (dly[i] < 0 || eff > cfg_t(d)) begin
                a       = r + cfg_t(d);
                eerr[i] = 1'b1;
            end else begin
                a = r + eff;
            end
            r = a + cfg_s(d);
        end
        a_last = a;
        e.kind = 1; e.ch = -1; e.edge_n = a; e.err = eerr;
        push_ev(d, e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) step();
    endtask

    task automatic check_reset(input int d, input string tag);
        logic [2:0] fl;
        fl = get_flags(d);
        chk({tag, "_ch_rst_n"}, d, get_ch(d), 0);
        chk({tag, "_err"}, d, get_err(d), 0);
        chk({tag, "_busy"}, d, fl[2], 1);
        chk({tag, "_ready"}, d, fl[1], 0);
        chk({tag, "_done"}, d, fl[0], 0);
    endtask

    task automatic nreset_release(input int d, output int a_last, output logic [15:0] eerr);
        plan(d, cyc + 2 + cfg_h(d), a_last, eerr);
        set_rstn(d, 1'b1);
    endtask

    task automatic nreset_restart(input int d, output int a_last, output logic [15:0] eerr);
        flush(d);
        clear_rdy(d);
        set_rstn(d, 1'b0);
        #1;
        check_reset(d, "nreset_async");
        repeat ($urandom_range(1, 3)) step();
        nreset_release(d, a_last, eerr);
    endtask

    task automatic soft_reset(input int d, input int hold_n, output int a_last, output logic [15:0] eerr);
        flush(d);
        clear_rdy(d);
        set_soft(d, 1'b1);
        step();
        check_reset(d, "soft");
        repeat (hold_n - 1) step();
        set_soft(d, 1'b0);
        plan(d, cyc + cfg_h(d), a_last, eerr);
    endtask

    task automatic finish_check(input int d, input int a_last, input logic [15:0] eerr);
        logic [2:0] fl;
        wait_until(a_last + 2);
        fl = get_flags(d);
        chk("final_ch_rst_n", d, get_ch(d), (d == 0) ? 16'hF : 16'h1);
        chk("final_err", d, get_err(d), eerr);
        chk("final_busy", d, fl[2], 0);
        chk("final_ready", d, fl[1], 1);
        chk("final_done", d, fl[0], 0);
        chk("scoreboard_drained", d, q_size(d), 0);
    endtask

    function automatic int rand_dly();
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return -1;
            2:       return 32;
            3:       return 33;
            default: return int'($urandom_range(1, 6));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          a;
        logic [15:0] e;
        clear_rdy(0);
        clear_rdy(1);
        repeat (3) step();
        check_reset(0, "por");
        check_reset(1, "por");

        // Ready one edge after each release, defaults otherwise.
        set_dly(1, 1, 1, 1);
        nreset_release(0, a, e);
        finish_check(0, a, e);

        // Channel 1 never reports ready: timeout, then sequence continues.
        set_dly(1, -1, 1, 1);
        soft_reset(0, 1, a, e);
        finish_check(0, a, e);

        // Board reset pulsed while waiting on channel 2, then full restart.
        set_dly(2, 3, 6, 2);
        soft_reset(0, 2, a, e);
        wait_until(exp_r[2] + 1);
        set_dly(1, 2, 3, 4);
        nreset_restart(0, a, e);
        finish_check(0, a, e);

        // Software reset held five cycles from RUN.
        set_dly(3, 1, 2, 1);
        soft_reset(0, 5, a, e);
        finish_check(0, a, e);

        // Channel 3 ready from the start must not shortcut the sequence.
        set_dly(2, 2, 2, 0);
        soft_reset(0, 1, a, e);
        finish_check(0, a, e);

        // Ready exactly at the timeout edge wins; one edge later is a timeout.
        set_dly(32, 33, 1, 1);
        soft_reset(0, 1, a, e);
        finish_check(0, a, e);

        // Randomized runs, some abandoned mid-sequence by the next restart.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 16; i++) dly[i] = -1;
            for (int i = 0; i < 4; i++) dly[i] = rand_dly();
            if ($urandom_range(0, 1) == 1) soft_reset(0, int'($urandom_range(1, 4)), a, e);
            else                           nreset_restart(0, a, e);
            if (it < 7 && $urandom_range(0, 2) == 0) wait_until(cyc + int'($urandom_range(1, a - cyc)));
            else                                     finish_check(0, a, e);
        end

        // Minimal configuration: one channel, one-cycle hold and stagger.
        set_dly(2, -1, -1, -1);
        nreset_release(1, a, e);
        finish_check(1, a, e);
        set_dly(-1, -1, -1, -1);
        soft_reset(1, 3, a, e);
        finish_check(1, a, e);
        set_dly(0, -1, -1, -1);
        nreset_restart(1, a, e);
        finish_check(1, a, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
